idli_sqi_mem_m: RTL and testbench

Synthesisable SQI (quad-SPI) SRAM responder: the memory end of the `idli_sqi_m` low/high memory interfaces. It decodes the serial command, address and data nibbles driven by the core and returns read data on the shared 4-bit bus. It is backed by an internal byte array and is used as the memory model in the bench and FPGA builds, one instance per interface (lo and hi).

---
 rtl/idli_pkg.sv | 29 ++
 rtl/idli_sqi_mem_ram_m.sv | 26 ++
 rtl/idli_sqi_mem_m.sv | 189 ++++++++++++++++++
 tb/tb_idli_sqi_mem_m.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/idli_pkg.sv
// Shared types and constants for the idli SQI memory responder.
package idli_pkg;

    typedef logic [3:0] slice_t;

    typedef enum logic [7:0] {
        SQI_CMD_WRITE = 8'h02,
        SQI_CMD_READ  = 8'h03
    } sqi_cmd_t;

    typedef enum logic [2:0] {
        SQI_MEM_IDLE,
        SQI_MEM_CMD,
        SQI_MEM_ADDR,
        SQI_MEM_DUMMY,
        SQI_MEM_RDATA,
        SQI_MEM_WDATA,
        SQI_MEM_IGNORE
    } sqi_mem_state_t;

    localparam int unsigned SQI_ADDR_NIBBLES  = 6;
    localparam int unsigned SQI_DUMMY_NIBBLES = 2;

    // Bytes travel high nibble first; lo selects the second nibble.
    function automatic slice_t sqi_nibble_sel(input logic [7:0] data, input logic lo);
        return lo ? data[3:0] : data[7:4];
    endfunction

endpackage

// File: rtl/idli_sqi_mem_ram_m.sv
// DEPTH x 8 byte array: combinational read port, synchronous write port.
// Kept separate so an FPGA build can swap in block RAM.
module idli_sqi_mem_ram_m #(
    parameter int DEPTH = 65536,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] mem_q [DEPTH];

    // NOTE: the array has no reset; contents survive reset, and a reset port would block RAM inference.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/idli_sqi_mem_m.sv
// SQI (quad-SPI) SRAM responder: decodes command/address/data nibbles and serves reads from a byte array.
// Define IDLI_SQI_MEM_DUMMY_EN to insert the 2-nibble dummy phase before read data.
module idli_sqi_mem_m
    import idli_pkg::*;
#(
    parameter int DEPTH = 65536,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic       i_mem_gck,
    input  logic       i_mem_rst,
    input  logic       i_mem_sck,
    input  logic       i_mem_cs,
    input  logic [3:0] i_mem_sio,
    output logic [3:0] o_mem_sio,
    output logic       o_mem_sio_oe
);

    localparam logic [2:0] ADDR_LAST  = 3'(SQI_ADDR_NIBBLES - 1);
    localparam logic [2:0] DUMMY_LAST = 3'(SQI_DUMMY_NIBBLES - 1);

    sqi_mem_state_t state_q, state_d;
    logic [2:0]     nib_cnt_q, nib_cnt_d;
    logic [AW-1:0]  addr_q, addr_d;
    slice_t         hold_q, hold_d;
    logic           is_wr_q, is_wr_d;
    logic           sck_q, sck_d;
    logic           cs_q, cs_d;
    slice_t         sio_q, sio_d;
    logic           oe_q, oe_d;

    logic           sck_rise;
    logic           sck_fall;
    logic           cs_fall;
    logic [7:0]     rise_byte;
    logic [AW+3:0]  addr_shift;
    logic           ram_we;
    logic [7:0]     ram_rdata;

    assign sck_d      = i_mem_sck;
    assign cs_d       = i_mem_cs;
    assign sck_rise   = i_mem_sck & ~sck_q;
    assign sck_fall   = ~i_mem_sck & sck_q;
    assign cs_fall    = cs_q & ~i_mem_cs;
    assign rise_byte  = {hold_q, i_mem_sio};
    assign addr_shift = {addr_q, i_mem_sio};

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        nib_cnt_d = nib_cnt_q;
        addr_d    = addr_q;
        hold_d    = hold_q;
        is_wr_d   = is_wr_q;
        sio_d     = sio_q;
        oe_d      = oe_q;
        ram_we    = 1'b0;

        if (i_mem_cs) begin
            // Deselect wins over any coincident sck edge and drops a half-received write byte.
            state_d   = SQI_MEM_IDLE;
            nib_cnt_d = '0;
            sio_d     = '0;
            oe_d      = 1'b0;
        end else begin
            if (state_q == SQI_MEM_IDLE) begin
                if (cs_fall) begin
                    state_d   = SQI_MEM_CMD;
                    nib_cnt_d = '0;
                end
            end else if (sck_rise) begin
                unique case (state_q)
                    SQI_MEM_CMD: begin
                        hold_d = i_mem_sio;
                        if (nib_cnt_q[0]) begin
                            nib_cnt_d = '0;
                            case (rise_byte)
                                SQI_CMD_READ: begin
                                    state_d = SQI_MEM_ADDR;
                                    is_wr_d = 1'b0;
                                end
                                SQI_CMD_WRITE: begin
                                    state_d = SQI_MEM_ADDR;
                                    is_wr_d = 1'b1;
                                end
                                default: state_d = SQI_MEM_IGNORE;
                            endcase
                        end else begin
                            nib_cnt_d = nib_cnt_q + 3'd1;
                        end
                    end
                    SQI_MEM_ADDR: begin
                        addr_d = addr_shift[AW-1:0];
                        if (nib_cnt_q == ADDR_LAST) begin
                            nib_cnt_d = '0;
                            if (is_wr_q) begin
                                state_d = SQI_MEM_WDATA;
                            end else begin
`ifdef IDLI_SQI_MEM_DUMMY_EN
                                state_d = SQI_MEM_DUMMY;
`else
                                state_d = SQI_MEM_RDATA;
`endif
                            end
                        end else begin
                            nib_cnt_d = nib_cnt_q + 3'd1;
                        end
                    end
                    SQI_MEM_DUMMY: begin
                        if (nib_cnt_q == DUMMY_LAST) begin
                            nib_cnt_d = '0;
                            state_d   = SQI_MEM_RDATA;
                        end else begin
                            nib_cnt_d = nib_cnt_q + 3'd1;
                        end
                    end
                    SQI_MEM_RDATA: begin
                        nib_cnt_d = {2'b00, ~nib_cnt_q[0]};
                        if (nib_cnt_q[0]) begin
                            addr_d = addr_q + AW'(1);
                        end
                    end
                    SQI_MEM_WDATA: begin
                        nib_cnt_d = {2'b00, ~nib_cnt_q[0]};
                        if (nib_cnt_q[0]) begin
                            ram_we = 1'b1;
                            addr_d = addr_q + AW'(1);
                        end else begin
                            hold_d = i_mem_sio;
                        end
                    end
                    SQI_MEM_IGNORE: state_d = SQI_MEM_IGNORE;
                    default:        state_d = SQI_MEM_IDLE;
                endcase
            end

            // Outputs only move on sck falls so they are settled at the initiator's next rise.
            if (sck_fall) begin
                if (state_q == SQI_MEM_RDATA) begin
                    oe_d  = 1'b1;
                    sio_d = sqi_nibble_sel(ram_rdata, nib_cnt_q[0]);
                end else begin
                    oe_d  = 1'b0;
                    sio_d = '0;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge i_mem_gck) begin
        if (i_mem_rst) begin
            state_q   <= SQI_MEM_IDLE;
            nib_cnt_q <= '0;
            addr_q    <= '0;
            hold_q    <= '0;
            is_wr_q   <= 1'b0;
            sck_q     <= 1'b0;
            cs_q      <= 1'b0;
            sio_q     <= '0;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            nib_cnt_q <= nib_cnt_d;
            addr_q    <= addr_d;
            hold_q    <= hold_d;
            is_wr_q   <= is_wr_d;
            sck_q     <= sck_d;
            cs_q      <= cs_d;
            sio_q     <= sio_d;
            oe_q      <= oe_d;
        end
    end

    idli_sqi_mem_ram_m #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (i_mem_gck),
        .i_we    (ram_we & ~i_mem_rst),
        .i_waddr (addr_q),
        .i_wdata (rise_byte),
        .i_raddr (addr_q),
        .o_rdata (ram_rdata)
    );

    assign o_mem_sio    = sio_q;
    assign o_mem_sio_oe = oe_q;

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Directed bench for idli_sqi_mem_m: transaction-level byte model plus per-rise output comparison.
module tb_idli_sqi_mem_m;

    localparam int DEPTH = 256;
`ifdef IDLI_SQI_MEM_DUMMY_EN
    localparam int DUMMY_N = 2;
`else
    localparam int DUMMY_N = 0;
`endif

    logic       gck    = 1'b0;
    logic       rst    = 1'b1;
    logic       sck    = 1'b0;
    logic       cs     = 1'b1;
    logic [3:0] sio_in = 4'h0;
    logic [3:0] sio_out;
    logic       oe;

    int total = 0;
    int bad   = 0;

    logic [7:0] model_mem [int];
    logic [7:0] rd_q [$];
    logic [7:0] wq [$];

    logic       exp_oe  = 1'b0;
    logic [3:0] exp_sio = 4'h0;
    string      exp_tag = "init";
    logic [3:0] last_sio;
    logic       cs_hi_q = 1'b0;

    always #5 gck = ~gck;

    idli_sqi_mem_m #(.DEPTH(DEPTH)) dut (
        .i_mem_gck    (gck),
        .i_mem_rst    (rst),
        .i_mem_sck    (sck),
        .i_mem_cs     (cs),
        .i_mem_sio    (sio_in),
        .o_mem_sio    (sio_out),
        .o_mem_sio_oe (oe)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Initiator view: outputs are sampled at each sck rise against the model's expectation.
    always @(posedge sck) begin
        check({exp_tag, "_oe"}, {7'd0, oe}, {7'd0, exp_oe});
        if (exp_oe) check({exp_tag, "_sio"}, {4'd0, sio_out}, {4'd0, exp_sio});
    end

    // A deselected responder must not drive one gck after cs was seen high.
    always @(posedge gck) cs_hi_q <= cs;
    always @(negedge gck) if (cs_hi_q) check("cs_high_oe", {7'd0, oe}, 8'd0);

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic int mi(input logic [23:0] addr, input int off);
        return (int'(addr) + off) % DEPTH;
    endfunction

    // All tasks start and end on a gck falling edge.
    task automatic pulse(input logic [3:0] nib, input logic e_oe, input logic [3:0] e_sio, input string tag);
        sio_in   = nib;
        exp_oe   = e_oe;
        exp_sio  = e_sio;
        exp_tag  = tag;
        last_sio = sio_out;
        sck      = 1'b1;
        repeat (2) @(negedge gck);
        sck = 1'b0;
        repeat (2) @(negedge gck);
    endtask

    task automatic cs_low();
        cs = 1'b0;
        repeat (2) @(negedge gck);
    endtask

    task automatic cs_high();
        cs = 1'b1;
        repeat (3) @(negedge gck);
    endtask

    task automatic send_hdr(input logic [7:0] cmd, input logic [23:0] addr, input string tag);
        pulse(cmd[7:4], 1'b0, 4'h0, tag);
        pulse(cmd[3:0], 1'b0, 4'h0, tag);
        for (int i = 5; i >= 0; i--) pulse(addr[4*i +: 4], 1'b0, 4'h0, tag);
    endtask

    task automatic do_write(input logic [23:0] addr, input string tag);
        cs_low();
        send_hdr(8'h02, addr, tag);
        for (int i = 0; i < wq.size(); i++) begin
            pulse(wq[i][7:4], 1'b0, 4'h0, tag);
            pulse(wq[i][3:0], 1'b0, 4'h0, tag);
            model_mem[mi(addr, i)] = wq[i];
        end
        cs_high();
    endtask

    task automatic do_read(input logic [23:0] addr, input int nbytes, input string tag);
        logic [7:0] e;
        logic [3:0] hi;
        cs_low();
        send_hdr(8'h03, addr, tag);
        for (int d = 0; d < DUMMY_N; d++) pulse(4'h0, 1'b0, 4'h0, tag);
        rd_q.delete();
        for (int b = 0; b < nbytes; b++) begin
            e = model_mem[mi(addr, b)];
            pulse(4'h0, 1'b1, e[7:4], tag);
            hi = last_sio;
            pulse(4'h0, 1'b1, e[3:0], tag);
            rd_q.push_back({hi, last_sio});
        end
        cs_high();
    endtask

    initial begin
        // Reset with cs already low: the responder must stay idle until cs toggles.
        cs = 1'b0;
        repeat (4) @(negedge gck);
        check("rst_oe", {7'd0, oe}, 8'd0);
        check("rst_sio", {4'd0, sio_out}, 8'd0);
        rst = 1'b0;
        @(negedge gck);
        send_hdr(8'h03, 24'h000010, "cs_low_at_reset");
        pulse(4'h0, 1'b0, 4'h0, "cs_low_at_reset");
        pulse(4'h0, 1'b0, 4'h0, "cs_low_at_reset");
        cs_high();

        // Write then read.
        wq.delete(); wq.push_back(8'hA5); wq.push_back(8'h3C);
        do_write(24'h000010, "wr_a5");
        do_read(24'h000010, 2, "rd_a5");
        check("rd_a5_b0", rd_q[0], 8'hA5);
        check("rd_a5_b1", rd_q[1], 8'h3C);

        // Upper address bits beyond the array are ignored.
        do_read(24'hAB0010, 1, "rd_trunc");
        check("rd_trunc_b0", rd_q[0], 8'hA5);

        // Wrap at the top of the array.
        wq.delete(); wq.push_back(8'h11); wq.push_back(8'h22);
        do_write(24'(DEPTH - 1), "wr_wrap");
        do_read(24'(DEPTH - 1), 2, "rd_wrap");
        check("rd_wrap_b0", rd_q[0], 8'h11);
        check("rd_wrap_b1", rd_q[1], 8'h22);
        do_read(24'h000000, 1, "rd_zero");
        check("rd_zero_b0", rd_q[0], 8'h22);

        // Abort after one write nibble leaves the byte unchanged.
        wq.delete(); wq.push_back(8'h5A);
        do_write(24'h000020, "wr_prior");
        cs_low();
        send_hdr(8'h02, 24'h000020, "wr_abort");
        pulse(4'hF, 1'b0, 4'h0, "wr_abort");
        cs_high();
        do_read(24'h000020, 1, "rd_abort");
        check("rd_abort_b0", rd_q[0], 8'h5A);

        // Unknown command 0x9F with 10 pulses total: nothing driven, nothing written.
        cs_low();
        pulse(4'h9, 1'b0, 4'h0, "unk");
        pulse(4'hF, 1'b0, 4'h0, "unk");
        pulse(4'h0, 1'b0, 4'h0, "unk");
        pulse(4'h0, 1'b0, 4'h0, "unk");
        pulse(4'h0, 1'b0, 4'h0, "unk");
        pulse(4'h0, 1'b0, 4'h0, "unk");
        pulse(4'h1, 1'b0, 4'h0, "unk");
        pulse(4'h0, 1'b0, 4'h0, "unk");
        pulse(4'hF, 1'b0, 4'h0, "unk");
        pulse(4'hF, 1'b0, 4'h0, "unk");
        cs_high();
        do_read(24'h000010, 2, "rd_after_unk");
        check("rd_after_unk_b0", rd_q[0], 8'hA5);
        check("rd_after_unk_b1", rd_q[1], 8'h3C);

        // Reset mid-read: outputs clear at once, and nothing is driven until cs toggles.
        cs_low();
        send_hdr(8'h03, 24'h000010, "rd_rst");
        for (int d = 0; d < DUMMY_N; d++) pulse(4'h0, 1'b0, 4'h0, "rd_rst");
        pulse(4'h0, 1'b1, 4'hA, "rd_rst");
        rst = 1'b1;
        @(negedge gck);
        check("mid_rst_oe", {7'd0, oe}, 8'd0);
        check("mid_rst_sio", {4'd0, sio_out}, 8'd0);
        rst = 1'b0;
        @(negedge gck);
        for (int i = 0; i < 4; i++) pulse(4'h0, 1'b0, 4'h0, "post_rst");
        cs_high();
        do_read(24'h000010, 2, "rd_post_rst");
        check("rd_post_rst_b0", rd_q[0], 8'hA5);

        // Longer burst across several bytes.
        wq.delete();
        wq.push_back(8'hDE); wq.push_back(8'hAD); wq.push_back(8'hBE); wq.push_back(8'hEF);
        do_write(24'h000080, "wr_burst");
        do_read(24'h000080, 4, "rd_burst");
        check("rd_burst_b0", rd_q[0], 8'hDE);
        check("rd_burst_b3", rd_q[3], 8'hEF);
        do_read(24'h000081, 2, "rd_burst_mid");
        check("rd_burst_mid_b0", rd_q[0], 8'hAD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
